// File: rtl/fir_input_feeder_if.sv
// Stream handshake bundle between the sample source, the feeder and the FIR core.
// slave  : feeder side (accepts source samples, presents samples to the core).
// master : environment side (drives source samples and the core's ready).
interface fir_input_feeder_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              fir_ready_for_input;
    logic              fir_input_valid;
    logic [DATA_W-1:0] fir_data;

    modport master (
        output in_valid,
        output in_data,
        output fir_ready_for_input,
        input  in_ready,
        input  fir_input_valid,
        input  fir_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  fir_ready_for_input,
        output in_ready,
        output fir_input_valid,
        output fir_data
    );
endinterface

// File: rtl/fir_input_feeder.sv
// Sample buffer in front of the FIR core controller: circular FIFO fed by a
// valid/ready stream, drained through a PRESENT/HOLD handshake so that the
// accepted sample stays on fir_data through the core's load cycle.
// Optional feature macro: FIR_IN_ALMOST_FULL_EN adds the almost_full output
// (count >= AF_THRESH, registered alongside count).
module fir_input_feeder #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8
`ifdef FIR_IN_ALMOST_FULL_EN
    ,
    parameter int unsigned AF_THRESH = 6
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    fir_input_feeder_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FIR_IN_ALMOST_FULL_EN
    ,
    output logic                         almost_full
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fir_data_q, fir_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty           = (count_q != '0);
    // Readiness looks at the registered count only; a pop in the same cycle
    // does not open a slot for a write when the FIFO is full.
    assign bus.in_ready        = rst && (count_q != CNT_W'(DEPTH));
    assign push                = bus.in_valid && bus.in_ready;
    assign bus.fir_input_valid = (state_q == PRESENT);
    assign bus.fir_data        = fir_data_q;
    assign level               = count_q;

    // Next-state decode; pops are issued only from IDLE and HOLD.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.fir_ready_for_input) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, occupancy and output-register updates driven by push/pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fir_data_d = fir_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            fir_data_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fir_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fir_data_q <= fir_data_d;
        end
    end

    // Sample storage; no reset needed since only written entries are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef FIR_IN_ALMOST_FULL_EN
    logic almost_full_q, almost_full_d;

    // Threshold compare on the next count so the flag tracks level exactly.
    always_comb begin
        almost_full_d = (count_d >= CNT_W'(AF_THRESH));
    end

    // Almost-full register, cleared in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule
